// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Two-port request arbiter and queue feeding a single-outstanding memory
//   interface controller. Each port owns an in-order request FIFO; the FSM
//   round-robins between non-empty FIFOs, issues one request downstream, waits
//   for its completion and routes the completion back to the issuing port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pN_req_valid/ready       port N request handshake (ready is registered)
//   pN_req_addr/wdata/we/be  port N request fields
//   pN_resp_valid            one-cycle completion pulse to port N
//   pN_resp_rdata/err        completion data and error flag for port N
//   dn_req_valid/ready       request handshake to the memory controller
//   dn_req_addr/wdata/we/be  head entry of the granted FIFO
//   dn_resp_valid/rdata/err  completion from the memory controller
//   busy                     FSM not idle or any FIFO holds entries
//   protocol_err             sticky: completion arrived with nothing outstanding
//
// FSM states
//   state     | meaning
//   S_IDLE    | nothing outstanding; arbitrate when any FIFO is non-empty
//   S_ISSUE   | present owner FIFO head downstream until accepted
//   S_WAIT    | request accepted; wait for its completion

module mem_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    p0_req_valid,
    output logic                    p0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
    input  logic [DATA_WIDTH-1:0]   p0_req_wdata,
    input  logic                    p0_req_we,
    input  logic [DATA_WIDTH/8-1:0] p0_req_be,
    output logic                    p0_resp_valid,
    output logic [DATA_WIDTH-1:0]   p0_resp_rdata,
    output logic                    p0_resp_err,

    input  logic                    p1_req_valid,
    output logic                    p1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
    input  logic [DATA_WIDTH-1:0]   p1_req_wdata,
    input  logic                    p1_req_we,
    input  logic [DATA_WIDTH/8-1:0] p1_req_be,
    output logic                    p1_resp_valid,
    output logic [DATA_WIDTH-1:0]   p1_resp_rdata,
    output logic                    p1_resp_err,

    output logic                    dn_req_valid,
    input  logic                    dn_req_ready,
    output logic [ADDR_WIDTH-1:0]   dn_req_addr,
    output logic [DATA_WIDTH-1:0]   dn_req_wdata,
    output logic                    dn_req_we,
    output logic [DATA_WIDTH/8-1:0] dn_req_be,
    input  logic                    dn_resp_valid,
    input  logic [DATA_WIDTH-1:0]   dn_resp_rdata,
    input  logic                    dn_resp_err,

    output logic                    busy,
    output logic                    protocol_err
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int EW   = ADDR_WIDTH + DATA_WIDTH + 1 + BE_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                state_q;
    logic                  owner_q;
    logic                  last_grant_q;
    logic                  grant;

    logic [EW-1:0]         mem_q      [2][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q   [2];
    logic [PW-1:0]         rd_ptr_q   [2];
    logic [CW-1:0]         cnt_q      [2];
    logic [CW-1:0]         cnt_d      [2];
    logic [1:0]            ready_q;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            not_empty;
    logic [EW-1:0]         wr_entry   [2];
    logic [EW-1:0]         head_entry;

    logic [1:0]            resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q [2];
    logic [1:0]            resp_err_q;
    logic                  protocol_err_q;

    assign wr_entry[0] = {p0_req_addr, p0_req_wdata, p0_req_we, p0_req_be};
    assign wr_entry[1] = {p1_req_addr, p1_req_wdata, p1_req_we, p1_req_be};

    always_comb begin
        push = {p1_req_valid & ready_q[1], p0_req_valid & ready_q[0]};
        pop  = 2'b00;
        if (state_q == S_ISSUE && dn_req_ready) begin
            pop[owner_q] = 1'b1;
        end
        for (int n = 0; n < 2; n++) begin
            not_empty[n] = (cnt_q[n] != '0);
            cnt_d[n]     = cnt_q[n];
            if (push[n] && !pop[n]) begin
                cnt_d[n] = cnt_q[n] + 1'b1;
            end else if (!push[n] && pop[n]) begin
                cnt_d[n] = cnt_q[n] - 1'b1;
            end
        end
    end

    // Round-robin: a lone requester always wins; on contention the port that
    // did not win last time goes next.
    always_comb begin
        grant = 1'b0;
        if (not_empty[0] && not_empty[1]) begin
            grant = ~last_grant_q;
        end else begin
            grant = not_empty[1];
        end
    end

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_q[n][wr_ptr_q[n]] <= wr_entry[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
            ready_q <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    wr_ptr_q[n] <= wr_ptr_q[n] + 1'b1;
                end
                if (pop[n]) begin
                    rd_ptr_q[n] <= rd_ptr_q[n] + 1'b1;
                end
                cnt_q[n]   <= cnt_d[n];
                ready_q[n] <= (cnt_d[n] < CW'(FIFO_DEPTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            owner_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            resp_valid_q    <= 2'b00;
            resp_rdata_q[0] <= '0;
            resp_rdata_q[1] <= '0;
            resp_err_q      <= 2'b00;
            protocol_err_q  <= 1'b0;
        end else begin
            resp_valid_q <= 2'b00;
            // A completion with nothing outstanding is dropped but remembered.
            if (dn_resp_valid && state_q != S_WAIT) begin
                protocol_err_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (|not_empty) begin
                        owner_q      <= grant;
                        last_grant_q <= grant;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dn_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dn_resp_valid) begin
                        resp_valid_q[owner_q] <= 1'b1;
                        resp_rdata_q[owner_q] <= dn_resp_rdata;
                        resp_err_q[owner_q]   <= dn_resp_err;
                        state_q               <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Head stays put until the pop, so the downstream fields are stable
    // for as long as dn_req_valid is held without ready.
    assign head_entry = mem_q[owner_q][rd_ptr_q[owner_q]];
    assign {dn_req_addr, dn_req_wdata, dn_req_we, dn_req_be} = head_entry;
    assign dn_req_valid = (state_q == S_ISSUE);

    assign p0_req_ready  = ready_q[0];
    assign p1_req_ready  = ready_q[1];
    assign p0_resp_valid = resp_valid_q[0];
    assign p1_resp_valid = resp_valid_q[1];
    assign p0_resp_rdata = resp_rdata_q[0];
    assign p1_resp_rdata = resp_rdata_q[1];
    assign p0_resp_err   = resp_err_q[0];
    assign p1_resp_err   = resp_err_q[1];

    assign busy         = (state_q != S_IDLE) || (|not_empty);
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req_valid = 0, p1_req_valid = 0;
    logic          p0_req_ready, p1_req_ready;
    logic [AW-1:0] p0_req_addr = '0, p1_req_addr = '0;
    logic [DW-1:0] p0_req_wdata = '0, p1_req_wdata = '0;
    logic          p0_req_we = 0, p1_req_we = 0;
    logic [BW-1:0] p0_req_be = '0, p1_req_be = '0;
    logic          p0_resp_valid, p1_resp_valid;
    logic [DW-1:0] p0_resp_rdata, p1_resp_rdata;
    logic          p0_resp_err, p1_resp_err;
    logic          dn_req_valid;
    logic          dn_req_ready = 0;
    logic [AW-1:0] dn_req_addr;
    logic [DW-1:0] dn_req_wdata;
    logic          dn_req_we;
    logic [BW-1:0] dn_req_be;
    logic          dn_resp_valid = 0;
    logic [DW-1:0] dn_resp_rdata = '0;
    logic          dn_resp_err = 0;
    logic          busy, protocol_err;

    always #5 clk = ~clk;

    mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_req_we(p0_req_we), .p0_req_be(p0_req_be),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_req_we(p1_req_we), .p1_req_be(p1_req_be),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
        .dn_req_addr(dn_req_addr), .dn_req_wdata(dn_req_wdata),
        .dn_req_we(dn_req_we), .dn_req_be(dn_req_be),
        .dn_resp_valid(dn_resp_valid), .dn_resp_rdata(dn_resp_rdata), .dn_resp_err(dn_resp_err),
        .busy(busy), .protocol_err(protocol_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
        logic [BW-1:0] be;
    } req_t;

    typedef struct {
        bit            port;
        bit            is_read;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    typedef enum {P_IDLE, P_ISSUE, P_WAIT} phase_t;

    // Reference model: per-port request queues, one outstanding request,
    // round-robin pick, and a scoreboard of expected port completions.
    req_t   mq0[$];
    req_t   mq1[$];
    exp_t   sb[$];
    phase_t phase    = P_IDLE;
    bit     owner    = 1'b0;
    bit     lg       = 1'b1;
    bit     cur_rd   = 1'b0;
    bit     perr     = 1'b0;
    bit     rst_prev = 1'b1;
    int     cyc      = 0;

    int     errors = 0;
    int     checks = 0;

    bit     hs_last = 1'b0;
    bit     pend    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        req_t h;
        bit   exp_now, ep, g, a0, a1;
        int   exp_ready0, exp_ready1;

        exp_ready0 = (!rst_prev && mq0.size() < D) ? 1 : 0;
        exp_ready1 = (!rst_prev && mq1.size() < D) ? 1 : 0;
        chk("p0_req_ready", 64'(p0_req_ready), 64'(exp_ready0));
        chk("p1_req_ready", 64'(p1_req_ready), 64'(exp_ready1));
        chk("dn_req_valid", 64'(dn_req_valid), 64'(phase == P_ISSUE));
        if (phase == P_ISSUE) begin
            h = owner ? mq1[0] : mq0[0];
            chk("dn_req_addr",  64'(dn_req_addr),  64'(h.addr));
            chk("dn_req_wdata", 64'(dn_req_wdata), 64'(h.wdata));
            chk("dn_req_we",    64'(dn_req_we),    64'(h.we));
            chk("dn_req_be",    64'(dn_req_be),    64'(h.be));
        end
        chk("busy", 64'(busy), 64'(phase != P_IDLE || mq0.size() > 0 || mq1.size() > 0));
        chk("protocol_err", 64'(protocol_err), 64'(perr));

        exp_now = (sb.size() > 0) && (sb[0].cyc == cyc);
        ep      = exp_now ? sb[0].port : 1'b0;
        chk("p0_resp_valid", 64'(p0_resp_valid), 64'(exp_now && !ep));
        chk("p1_resp_valid", 64'(p1_resp_valid), 64'(exp_now && ep));
        if (exp_now) begin
            if (sb[0].is_read) begin
                chk("resp_rdata", 64'(ep ? p1_resp_rdata : p0_resp_rdata), 64'(sb[0].rdata));
            end
            chk("resp_err", 64'(ep ? p1_resp_err : p0_resp_err), 64'(sb[0].err));
            void'(sb.pop_front());
        end
        if (rst_prev) begin
            chk("p0_rdata_rst", 64'(p0_resp_rdata), 64'd0);
            chk("p1_rdata_rst", 64'(p1_resp_rdata), 64'd0);
            chk("p0_err_rst",   64'(p0_resp_err),   64'd0);
            chk("p1_err_rst",   64'(p1_resp_err),   64'd0);
        end

        if (rst) begin
            mq0.delete();
            mq1.delete();
            sb.delete();
            phase    = P_IDLE;
            owner    = 1'b0;
            lg       = 1'b1;
            perr     = 1'b0;
            rst_prev = 1'b1;
        end else begin
            a0 = p0_req_valid && (exp_ready0 != 0);
            a1 = p1_req_valid && (exp_ready1 != 0);
            if (dn_resp_valid && phase != P_WAIT) perr = 1'b1;
            case (phase)
                P_IDLE: begin
                    if (mq0.size() > 0 || mq1.size() > 0) begin
                        if (mq0.size() > 0 && mq1.size() > 0) g = !lg;
                        else g = (mq1.size() > 0);
                        lg    = g;
                        owner = g;
                        phase = P_ISSUE;
                    end
                end
                P_ISSUE: begin
                    if (dn_req_ready) begin
                        h      = owner ? mq1.pop_front() : mq0.pop_front();
                        cur_rd = !h.we;
                        phase  = P_WAIT;
                    end
                end
                default: begin
                    if (dn_resp_valid) begin
                        sb.push_back('{owner, cur_rd, dn_resp_rdata, dn_resp_err, cyc + 1});
                        phase = P_IDLE;
                    end
                end
            endcase
            if (a0) mq0.push_back('{p0_req_addr, p0_req_wdata, p0_req_we, p0_req_be});
            if (a1) mq1.push_back('{p1_req_addr, p1_req_wdata, p1_req_we, p1_req_be});
            rst_prev = 1'b0;
        end
        cyc++;
    end

    // One clock: observe the end of the current cycle, then step past the edge.
    task automatic tick();
        @(negedge clk);
        hs_last = dn_req_valid && dn_req_ready && !rst;
        if (rst) pend = 1'b0;
        else if (hs_last) pend = 1'b1;
        else if (dn_resp_valid) pend = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req_valid  = 0;
        p1_req_valid  = 0;
        dn_resp_valid = 0;
        dn_resp_err   = 0;
    endtask

    task automatic drive_cycle(input int req_pct, input int spur_pct, input int err_pct, input int rdy_pct);
        p0_req_valid = ($urandom % 100) < req_pct;
        p0_req_addr  = $urandom;
        p0_req_wdata = $urandom;
        p0_req_we    = $urandom % 2;
        p0_req_be    = BW'($urandom);
        p1_req_valid = ($urandom % 100) < req_pct;
        p1_req_addr  = $urandom;
        p1_req_wdata = $urandom;
        p1_req_we    = $urandom % 2;
        p1_req_be    = BW'($urandom);
        dn_req_ready = ($urandom % 100) < rdy_pct;
        dn_resp_rdata = $urandom;
        if (pend && ($urandom % 100) < 60) begin
            dn_resp_valid = 1;
            dn_resp_err   = ($urandom % 100) < err_pct;
        end else begin
            dn_resp_valid = !pend && (($urandom % 100) < spur_pct);
            dn_resp_err   = 0;
        end
        tick();
    endtask

    task automatic wait_hs(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (hs_last) return;
            tick();
        end
        if (!hs_last) begin
            checks++;
            errors++;
            $display("FAIL wait_hs: no downstream handshake within %0d cycles", limit);
        end
    endtask

    task automatic respond(input logic [DW-1:0] d, input logic e);
        dn_resp_valid = 1;
        dn_resp_rdata = d;
        dn_resp_err   = e;
        tick();
        dn_resp_valid = 0;
        dn_resp_err   = 0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            drive_cycle(0, 0, 0, 100);
            if (!busy && !pend) break;
        end
        idle_inputs();
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL drain: still busy after %0d cycles", limit);
        end
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 0;
        repeat (2) tick();

        // Single read on port 0, completion two cycles after acceptance.
        dn_req_ready = 1;
        p0_req_valid = 1; p0_req_addr = 32'h100; p0_req_we = 0; p0_req_be = 4'hF; p0_req_wdata = '0;
        tick();
        p0_req_valid = 0;
        wait_hs(20);
        tick();
        respond(32'hDEADBEEF, 0);
        repeat (3) tick();

        // Fill port 1 with writes while the controller stalls; fifth is refused.
        dn_req_ready = 0;
        for (int k = 0; k < 5; k++) begin
            p1_req_valid = 1; p1_req_we = 1; p1_req_be = 4'hF;
            p1_req_addr = 32'h2000 + 32'(k * 4); p1_req_wdata = $urandom;
            tick();
        end
        p1_req_valid = 0;
        repeat (3) tick();
        dn_req_ready = 1;
        tick();
        dn_req_ready = 0;
        repeat (2) tick();
        drain(80);

        // Write completing with an error, followed by a queued read.
        dn_req_ready = 1;
        p0_req_valid = 1; p0_req_we = 1; p0_req_be = 4'hF; p0_req_addr = 32'h300; p0_req_wdata = $urandom;
        tick();
        p0_req_we = 0; p0_req_addr = 32'h304;
        tick();
        p0_req_valid = 0;
        wait_hs(20);
        respond(32'h0BAD, 1);
        drain(80);

        // Completion while idle: dropped, sticky protocol error.
        dn_resp_valid = 1; dn_resp_rdata = 32'h1234;
        tick();
        dn_resp_valid = 0;
        repeat (3) tick();

        // Both ports push three requests in the same cycles.
        dn_req_ready = 1;
        for (int k = 0; k < 3; k++) begin
            p0_req_valid = 1; p0_req_addr = 32'h400 + 32'(k); p0_req_we = 0; p0_req_wdata = $urandom; p0_req_be = 4'h3;
            p1_req_valid = 1; p1_req_addr = 32'h500 + 32'(k); p1_req_we = 1; p1_req_wdata = $urandom; p1_req_be = 4'hC;
            tick();
        end
        idle_inputs();
        drain(100);

        // Random traffic with occasional stray completions.
        repeat (1500) drive_cycle(35, 2, 20, 70);
        idle_inputs();
        drain(200);

        // Reset while a request is outstanding and two more are queued.
        dn_req_ready = 1;
        for (int k = 0; k < 3; k++) begin
            p0_req_valid = 1; p0_req_addr = 32'h600 + 32'(k); p0_req_we = 0;
            tick();
        end
        p0_req_valid = 0;
        wait_hs(20);
        tick();
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        repeat (3) tick();
        dn_resp_valid = 1; dn_resp_rdata = 32'hCAFE;
        tick();
        dn_resp_valid = 0;
        repeat (3) tick();

        // Random traffic with sporadic resets.
        for (int i = 0; i < 1000; i++) begin
            rst = (($urandom % 150) == 0);
            drive_cycle(40, 1, 10, 60);
        end
        rst = 0;
        idle_inputs();
        tick();
        drain(200);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
